// File: rtl/fetch_branch_unit_if.sv
// Instruction-memory bus between the fetch unit and instruction memory.
//   imem_addr  : fetch address (driven by the fetch unit)
//   imem_rdata : instruction word, combinational read of imem_addr
// master = fetch unit, slave = instruction memory.
interface fetch_branch_unit_if;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;

  modport master (output imem_addr, input imem_rdata);
  modport slave  (input imem_addr, output imem_rdata);
endinterface

// File: rtl/fetch_branch_unit.sv
// Instruction-fetch stage with branch resolution for the instruction in ID.
// Holds the PC, fetches through the imem bus, registers the fetched word
// into IF/ID and redirects/squashes on taken BEZ/BNE/JMP.
// Ports:
//   clk, rst_n        : clock, synchronous active-low reset
//   freeze            : hazard stall, holds PC, IF/ID and counter
//   id_*              : valid, branch type, operands, imm, PC+4 of ID instr
//   imem              : instruction-memory bus (master side)
//   if_id_*           : registered instruction, PC+4 and valid to ID
//   branch_taken      : combinational redirect indication
//   branch_target     : combinational target address
//   taken_count       : saturating count of taken branches since reset
module fetch_branch_unit #(
  parameter logic [31:0] RESET_PC = 32'd0,
  parameter logic [31:0] PC_STEP  = 32'd4,
  parameter int unsigned CNT_W    = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  freeze,
  input  logic                  id_valid,
  input  logic [1:0]            id_branch_type,
  input  logic [31:0]           id_val1,
  input  logic [31:0]           id_val2,
  input  logic [15:0]           id_imm,
  input  logic [31:0]           id_pc_plus4,
  fetch_branch_unit_if.master   imem,
  output logic [31:0]           if_id_instr,
  output logic [31:0]           if_id_pc_plus4,
  output logic                  if_id_valid,
  output logic                  branch_taken,
  output logic [31:0]           branch_target,
  output logic [CNT_W-1:0]      taken_count
);

  typedef enum logic [1:0] {
    BR_NONE = 2'b00,
    BR_BEZ  = 2'b01,
    BR_BNE  = 2'b10,
    BR_JMP  = 2'b11
  } br_type_t;

  logic [31:0] pc;
  logic [31:0] pc_next_seq;
  logic        cond;
  br_type_t    br_type;

  assign br_type     = br_type_t'(id_branch_type);
  assign pc_next_seq = pc + PC_STEP;
  assign imem.imem_addr = pc;

  // Word offset: sign-extend and scale by 4; 32-bit wrap is intentional.
  assign branch_target = id_pc_plus4 + {{14{id_imm[15]}}, id_imm, 2'b00};

  always_comb begin
    cond = 1'b0;
    unique case (br_type)
      BR_NONE: cond = 1'b0;
      BR_BEZ:  cond = (id_val1 == '0);
      BR_BNE:  cond = (id_val1 != id_val2);
      BR_JMP:  cond = 1'b1;
      default: cond = 1'b0;
    endcase
  end

  // Operands are not final while frozen, so freeze suppresses the redirect.
  assign branch_taken = id_valid & ~freeze & cond;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc             <= RESET_PC;
      if_id_instr    <= '0;
      if_id_pc_plus4 <= '0;
      if_id_valid    <= 1'b0;
      taken_count    <= '0;
    end else if (freeze) begin
      pc             <= pc;
      if_id_instr    <= if_id_instr;
      if_id_pc_plus4 <= if_id_pc_plus4;
      if_id_valid    <= if_id_valid;
      taken_count    <= taken_count;
    end else if (branch_taken) begin
      // Squash the wrong-path fetch; the bubble is the single-cycle penalty.
      pc             <= branch_target;
      if_id_instr    <= '0;
      if_id_pc_plus4 <= '0;
      if_id_valid    <= 1'b0;
      if (taken_count != '1)
        taken_count <= taken_count + 1'b1;
    end else begin
      pc             <= pc_next_seq;
      if_id_instr    <= imem.imem_rdata;
      if_id_pc_plus4 <= pc_next_seq;
      if_id_valid    <= 1'b1;
    end
  end

endmodule
